// File: rtl/iq_phase_extractor.sv
// Pipelined CORDIC vectoring core: converts I/Q samples into phase and magnitude,
// then derives the sample-to-sample phase difference and an unwrapped phase.
module iq_phase_extractor #(
  parameter int AMPLITUDE_BITS = 14,
  parameter int PHASE_BITS     = 16,
  parameter int STAGES         = 14,
  parameter int ACCUM_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IN_VALID,
  input  logic [AMPLITUDE_BITS-1:0] COS_IN,
  input  logic [AMPLITUDE_BITS-1:0] SINE_IN,
  output logic                      OUT_VALID,
  output logic [PHASE_BITS-1:0]     PHASE_WORD,
  output logic [AMPLITUDE_BITS:0]   MAGNITUDE,
  output logic [PHASE_BITS-1:0]     PHASE_DIFF,
  output logic [ACCUM_WIDTH-1:0]    PHASE_UNWRAPPED
);

  localparam int FRAC = 3;
  localparam int W    = AMPLITUDE_BITS + 2 + FRAC;
  localparam logic [PHASE_BITS-1:0] HALF_TURN = {1'b1, {(PHASE_BITS-1){1'b0}}};
  localparam int ROUND_HALF = 1 << (FRAC - 1);

  // atan(2^-k) in phase LSBs, rounded; series converges quickly for k >= 1.
  function automatic logic [PHASE_BITS-1:0] atan_lsb(input int k);
    real x, x2, term, sum;
    x = 1.0;
    for (int j = 0; j < k; j++) x = x / 2.0;
    if (k == 0) begin
      sum = 0.7853981633974483;
    end else begin
      x2   = x * x;
      term = x;
      sum  = 0.0;
      for (int n = 0; n < 32; n++) begin
        if (n % 2 == 0) sum = sum + term / real'(2 * n + 1);
        else            sum = sum - term / real'(2 * n + 1);
        term = term * x2;
      end
    end
    return PHASE_BITS'($rtoi(sum * (2.0 ** PHASE_BITS) / 6.283185307179586 + 0.5));
  endfunction

  logic signed [AMPLITUDE_BITS:0] cos_ext, sin_ext, cos_rot, sin_rot;
  logic signed [W-1:0]            x_init, y_init;
  logic                           negate, zero_in;

  logic signed [W-1:0]     x_reg  [0:STAGES];
  logic signed [W-1:0]     y_reg  [0:STAGES-1];
  logic [PHASE_BITS-1:0]   z_reg  [0:STAGES];
  logic [STAGES:0]         valid_reg;
  logic [STAGES:0]         zero_reg;

  logic signed [W-1:0]     x_next [0:STAGES-1];
  logic signed [W-1:0]     y_next [0:STAGES-2];
  logic [PHASE_BITS-1:0]   z_next [0:STAGES-1];

  // Left half-plane is folded into the right by a 180 degree rotation.
  assign negate  = COS_IN[AMPLITUDE_BITS-1];
  assign zero_in = (COS_IN == '0) && (SINE_IN == '0);
  assign cos_ext = {COS_IN[AMPLITUDE_BITS-1], COS_IN};
  assign sin_ext = {SINE_IN[AMPLITUDE_BITS-1], SINE_IN};
  assign cos_rot = negate ? -cos_ext : cos_ext;
  assign sin_rot = negate ? -sin_ext : sin_ext;
  assign x_init  = {cos_rot[AMPLITUDE_BITS], cos_rot, {FRAC{1'b0}}};
  assign y_init  = {sin_rot[AMPLITUDE_BITS], sin_rot, {FRAC{1'b0}}};

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_iter
      localparam logic [PHASE_BITS-1:0] ANGLE = atan_lsb(gi);
      logic y_neg;
      assign y_neg       = y_reg[gi][W-1];
      assign x_next[gi]  = y_neg ? x_reg[gi] - (y_reg[gi] >>> gi) : x_reg[gi] + (y_reg[gi] >>> gi);
      assign z_next[gi]  = y_neg ? z_reg[gi] - ANGLE : z_reg[gi] + ANGLE;
      // The last iteration's Q is not needed downstream.
      if (gi < STAGES - 1) begin : g_y
        assign y_next[gi] = y_neg ? y_reg[gi] + (x_reg[gi] >>> gi) : y_reg[gi] - (x_reg[gi] >>> gi);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) valid_reg <= '0;
    else     valid_reg <= {valid_reg[STAGES-1:0], IN_VALID};
    zero_reg <= {zero_reg[STAGES-1:0], zero_in};
    x_reg[0] <= x_init;
    y_reg[0] <= y_init;
    z_reg[0] <= negate ? HALF_TURN : '0;
    for (int k = 0; k < STAGES; k++) begin
      x_reg[k+1] <= x_next[k];
      z_reg[k+1] <= z_next[k];
      if (k < STAGES - 1) y_reg[k+1] <= y_next[k];
    end
  end

  logic signed [W-1:0]         x_last;
  logic signed [W:0]           x_round, mag_int;
  logic [AMPLITUDE_BITS:0]     mag_sat;
  logic [PHASE_BITS-1:0]       phase_final, diff;
  logic                        first_reg;

  assign x_last      = x_reg[STAGES];
  assign x_round     = $signed({x_last[W-1], x_last}) + $signed((W+1)'(ROUND_HALF));
  assign mag_int     = x_round >>> FRAC;
  assign phase_final = zero_reg[STAGES] ? '0 : z_reg[STAGES];
  assign diff        = phase_final - PHASE_WORD;

  always_comb begin
    mag_sat = mag_int[AMPLITUDE_BITS:0];
    if (zero_reg[STAGES] || mag_int[W])         mag_sat = '0;
    else if (|mag_int[W-1:AMPLITUDE_BITS+1])    mag_sat = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_VALID       <= 1'b0;
      PHASE_WORD      <= '0;
      MAGNITUDE       <= '0;
      PHASE_DIFF      <= '0;
      PHASE_UNWRAPPED <= '0;
      first_reg       <= 1'b1;
    end else begin
      OUT_VALID <= valid_reg[STAGES];
      if (valid_reg[STAGES]) begin
        PHASE_WORD <= phase_final;
        MAGNITUDE  <= mag_sat;
        if (first_reg) begin
          PHASE_DIFF      <= '0;
          PHASE_UNWRAPPED <= {{(ACCUM_WIDTH-PHASE_BITS){1'b0}}, phase_final};
          first_reg       <= 1'b0;
        end else begin
          PHASE_DIFF      <= diff;
          PHASE_UNWRAPPED <= PHASE_UNWRAPPED + {{(ACCUM_WIDTH-PHASE_BITS){diff[PHASE_BITS-1]}}, diff};
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_phase_extractor.sv
// Randomised bench for iq_phase_extractor: a real-arithmetic atan2/sqrt model
// scheduled by cycle is compared against every output on every cycle.
module tb_iq_phase_extractor;
  localparam int  A     = 14;
  localparam int  P     = 16;
  localparam int  S     = 14;
  localparam int  AW    = 32;
  localparam int  LAT   = S + 2;
  localparam int  SCHED = 4096;
  localparam real PI    = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [A-1:0]         cos_in, sine_in;
  logic                 out_valid;
  logic [P-1:0]         phase_word;
  logic [A:0]           magnitude;
  logic signed [P-1:0]  phase_diff;
  logic signed [AW-1:0] phase_unwrapped;

  iq_phase_extractor #(.AMPLITUDE_BITS(A), .PHASE_BITS(P), .STAGES(S), .ACCUM_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .COS_IN(cos_in), .SINE_IN(sine_in),
    .OUT_VALID(out_valid), .PHASE_WORD(phase_word), .MAGNITUDE(magnitude),
    .PHASE_DIFF(phase_diff), .PHASE_UNWRAPPED(phase_unwrapped)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-edge schedule: 1 = a sample's result becomes visible, 2 = reset takes effect.
  int sched_kind [SCHED];
  int sched_i    [SCHED];
  int sched_q    [SCHED];

  typedef struct { int phase; int mag; int diff; int unwr; } cap_t;
  cap_t cap[$];

  bit  m_valid, m_first, checking;
  real m_phase, m_mag, m_diff, m_unwr, m_ptol, m_dtol;

  task automatic chk_tol(input string name, input real act, input real exp, input real tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %.2f, required %.2f +/- %.1f (edge %0d)", name, act, exp, tol, edge_n);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic real cordic_gain();
    real g = 1.0;
    for (int k = 0; k < S; k++) g = g * $sqrt(1.0 + 2.0 ** (-2 * k));
    return g;
  endfunction

  function automatic real wrap_turn(input real d);
    real r = d;
    while (r >= 32768.0) r = r - 65536.0;
    while (r < -32768.0) r = r + 65536.0;
    return r;
  endfunction

  task automatic apply_event(input int kind, input int i, input int q);
    real p, r, tol;
    if (kind == 2) begin
      m_valid = 0; m_first = 1; checking = 1;
      m_phase = 0.0; m_mag = 0.0; m_diff = 0.0; m_unwr = 0.0;
      m_ptol = 0.5; m_dtol = 0.5;
    end else if (kind == 1) begin
      if (i == 0 && q == 0) begin
        p = 0.0; r = 0.0; tol = 0.5;
      end else begin
        p = $atan2(real'(q), real'(i)) * 65536.0 / (2.0 * PI);
        if (p < 0.0) p = p + 65536.0;
        r = cordic_gain() * $sqrt(real'(i * i + q * q));
        tol = 4.5;
      end
      if (m_first) begin
        m_diff = 0.0; m_dtol = 0.5; m_unwr = p; m_first = 0;
      end else begin
        m_diff = wrap_turn(p - m_phase);
        m_dtol = tol + m_ptol;
        m_unwr = m_unwr + m_diff;
      end
      m_phase = p; m_mag = r; m_ptol = tol; m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  // Compare process: every cycle, all outputs against the model.
  initial begin
    int  m;
    real ex;
    forever begin
      @(negedge clk);
      m = edge_n;
      if (m < SCHED) apply_event(sched_kind[m], sched_i[m], sched_q[m]);
      if (checking) begin
        chk_eq("out_valid", int'(out_valid), int'(m_valid));
        ex = m_phase;
        while (real'(phase_word) - ex > 32768.0) ex = ex + 65536.0;
        while (real'(phase_word) - ex < -32768.0) ex = ex - 65536.0;
        chk_tol("phase_word", real'(phase_word), ex, m_ptol);
        chk_tol("magnitude", real'(magnitude), m_mag, m_ptol);
        chk_tol("phase_diff", real'(phase_diff), m_diff, m_dtol);
        chk_tol("phase_unwrapped", real'(phase_unwrapped), m_unwr, m_ptol);
      end
      if (out_valid) begin
        cap.push_back('{int'(phase_word), int'(magnitude), int'(phase_diff), int'(phase_unwrapped)});
        $display("out %0d: phase=%0d mag=%0d diff=%0d unwrapped=%0d",
                 cap.size() - 1, phase_word, magnitude, phase_diff, phase_unwrapped);
      end
    end
  end

  task automatic drive(input logic r, input logic v, input int i, input int q);
    int idx;
    idx = edge_n + 1;
    if (idx + LAT >= SCHED) begin
      $display("FAIL schedule_overflow: edge %0d beyond %0d", idx, SCHED);
      $fatal(1);
    end
    rst = r; in_valid = v; cos_in = A'(i); sine_in = A'(q);
    if (r) begin
      for (int k = idx; k <= idx + LAT; k++) sched_kind[k] = 0;
      sched_kind[idx] = 2;
    end else if (v) begin
      sched_kind[idx + LAT - 1] = 1;
      sched_i[idx + LAT - 1] = i;
      sched_q[idx + LAT - 1] = q;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v;
  endfunction

  task automatic sample_at(input real phase_lsb, input real amp);
    real th;
    th = phase_lsb * 2.0 * PI / 65536.0;
    drive(1'b0, 1'b1, rnd(amp * $cos(th)), rnd(amp * $sin(th)));
  endtask

  function automatic int phase_err(input int act, input int exp);
    int d;
    d = ((act - exp) % 65536 + 65536) % 65536;
    return (d >= 32768) ? d - 65536 : d;
  endfunction

  int ax_i  [6] = '{0, -8191, 0, 8191, -8192, 0};
  int ax_q  [6] = '{8191, 0, -8192, 0, -8192, 0};
  int ax_p  [6] = '{16384, 32768, 49152, 0, 40960, 0};
  int ax_m  [6] = '{13489, 13489, 13489, 13489, 19079, 0};
  int ax_t  [6] = '{4, 4, 4, 4, 4, 0};

  initial begin
    int base, nvalid, prev, step;
    rst = 1'b1; in_valid = 1'b0; cos_in = '0; sine_in = '0;
    repeat (3) drive(1'b1, 1'b0, 0, 0);
    chk_eq("reset out_valid", int'(out_valid), 0);
    chk_eq("reset phase_word", int'(phase_word), 0);
    chk_eq("reset magnitude", int'(magnitude), 0);
    chk_eq("reset phase_diff", int'(phase_diff), 0);
    chk_eq("reset phase_unwrapped", int'(phase_unwrapped), 0);

    // Axes and extremes, spaced by bubbles.
    base = cap.size();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, ax_i[k], ax_q[k]);
      idle(3);
    end
    idle(LAT + 2);
    chk_eq("axes output count", cap.size() - base, 6);
    if (cap.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk_tol("axis phase", real'(cap[base+k].phase),
                real'(cap[base+k].phase - phase_err(cap[base+k].phase, ax_p[k])), real'(ax_t[k]));
        chk_tol("axis magnitude", real'(cap[base+k].mag), real'(ax_m[k]), real'(ax_t[k]));
      end
    end

    // Positive ramp through several wraps, then 65000 -> 500.
    drive(1'b1, 1'b0, 0, 0);
    base = cap.size();
    for (int k = 0; k < 200; k++) sample_at(1000.0 + 1000.0 * k, 8000.0);
    sample_at(65000.0, 8000.0);
    sample_at(500.0, 8000.0);
    idle(LAT + 2);
    chk_eq("ramp output count", cap.size() - base, 202);
    if (cap.size() >= base + 202) begin
      for (int k = 1; k < 200; k++) chk_tol("ramp diff", real'(cap[base+k].diff), 1000.0, 8.0);
      chk_tol("ramp unwrapped end", real'(cap[base+199].unwr), 200000.0, 8.0);
      chk_tol("wrap diff 65000->500", real'(cap[base+201].diff), 1036.0, 8.0);
    end

    // Negative ramp.
    drive(1'b1, 1'b0, 0, 0);
    base = cap.size();
    for (int k = 0; k < 60; k++) sample_at(30000.0 - 3000.0 * k, 8000.0);
    idle(LAT + 2);
    chk_eq("neg ramp output count", cap.size() - base, 60);
    if (cap.size() >= base + 60) begin
      for (int k = 1; k < 60; k++) chk_tol("neg ramp diff", real'(cap[base+k].diff), -3000.0, 8.0);
      chk_tol("neg ramp unwrapped end", real'(cap[base+59].unwr), -147000.0, 8.0);
    end

    // Random bubbles, random amplitude and phase steps, occasional zero sample.
    drive(1'b1, 1'b0, 0, 0);
    base = cap.size();
    nvalid = 0;
    prev = 20000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        nvalid++;
        if ($urandom_range(15, 0) == 0 && k > 0) begin
          prev = 0;
          drive(1'b0, 1'b1, 0, 0);
        end else begin
          step = int'($urandom_range(60000, 0)) - 30000;
          prev = ((prev + step) % 65536 + 65536) % 65536;
          sample_at(real'(prev), real'($urandom_range(8191, 4200)));
        end
      end else begin
        drive(1'b0, 1'b0, int'($urandom_range(8191, 0)), int'($urandom_range(8191, 0)));
      end
    end
    idle(LAT + 2);
    chk_eq("bubble output count", cap.size() - base, nvalid);

    // Reset with ten samples in flight; IN_VALID during reset is ignored.
    drive(1'b1, 1'b0, 0, 0);
    idle(2);
    base = cap.size();
    for (int k = 0; k < 10; k++) sample_at(5000.0 * k + 300.0, 7000.0);
    drive(1'b1, 1'b1, 4000, 4000);
    for (int k = 0; k < 5; k++) sample_at(12000.0 + 2000.0 * k, 7000.0);
    idle(LAT + 2);
    chk_eq("post-reset output count", cap.size() - base, 5);
    if (cap.size() > base) chk_eq("post-reset first diff", cap[base].diff, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
